// File: rtl/dmg_lcd_capture.sv
// dmg_lcd_capture: captures the DMG LCD pixel stream, packs four 2-bit shades
// per byte and queues {addr, byte} writes towards a framebuffer RAM through a
// small write FIFO.
// Optional feature macro: DMG_LCD_CAPTURE_DOUBLE_BUFFER_EN
//   defined   -> ping-pong buffers, fb_front flips on frame completion and
//                writes target the back buffer (addr bit13 = ~fb_front)
//   undefined -> single buffer, fb_front = 0 and addr bit13 = 0
module dmg_lcd_capture #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_vsync,
    input  logic        lcd_hsync,
    input  logic        lcd_pixel,
    input  logic [1:0]  lcd_color,
    output logic        fb_wr_valid,
    input  logic        fb_wr_ready,
    output logic [13:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        fb_front,
    output logic        frame_done,
    output logic        overflow,
    output logic        line_err
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  LINE_PIX  = 8'd160;
    localparam logic [7:0]  LAST_LINE = 8'd143;
    localparam logic [12:0] LAST_ADDR = 13'd5759;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_x, r_y;
    logic [7:0]  r_pack;
    logic        r_overflow, r_line_err, r_frame_done;

    logic [21:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr, r_rptr;

    logic        w_act, w_pix_ok, w_pix_bad, w_hs, w_push;
    logic        w_empty, w_full, w_pop, w_wr, w_last;
    logic        w_back;
    logic [12:0] w_lin;
    logic [21:0] w_head;

`ifdef DMG_LCD_CAPTURE_DOUBLE_BUFFER_EN
    logic r_front;
    assign w_back   = ~r_front;
    assign fb_front = r_front;
`else
    assign w_back   = 1'b0;
    assign fb_front = 1'b0;
`endif

    // vsync has priority over everything; hsync wins over a coincident pixel
    assign w_act     = (r_state == S_ACTIVE) && !lcd_vsync;
    assign w_hs      = w_act && lcd_hsync;
    assign w_pix_ok  = w_act && !lcd_hsync && lcd_pixel && (r_x <  LINE_PIX);
    assign w_pix_bad = w_act && !lcd_hsync && lcd_pixel && (r_x >= LINE_PIX);
    assign w_push    = w_pix_ok && (r_x[1:0] == 2'b11);
    assign w_lin     = ({5'b0, r_y} * 13'd40) + {7'b0, r_x[7:2]};

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && fb_wr_ready;
    // a pop in the same clk frees the slot, so a full FIFO can still accept
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_head  = r_mem[r_rptr[AW-1:0]];
    assign w_last  = w_pop && (w_head[20:8] == LAST_ADDR);

    // outputs are forced to zero when empty so stale entries never show
    assign fb_wr_valid = !w_empty;
    assign fb_addr     = w_empty ? 14'd0 : w_head[21:8];
    assign fb_data     = w_empty ? 8'd0  : w_head[7:0];
    assign frame_done  = r_frame_done;
    assign overflow    = r_overflow;
    assign line_err    = r_line_err;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // next-state: the frame ends on the hsync that closes line 143
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (lcd_vsync) w_state_nxt = S_ACTIVE;
            S_ACTIVE: begin
                if (lcd_vsync)                           w_state_nxt = S_ACTIVE;
                else if (lcd_hsync && r_y == LAST_LINE)  w_state_nxt = S_DONE;
            end
            S_DONE:   if (lcd_vsync) w_state_nxt = S_ACTIVE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // pixel/line counters and the shift-right pack register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_pack <= '0;
        end else if (lcd_vsync) begin
            r_x    <= '0;
            r_y    <= '0;
            r_pack <= '0;
        end else if (w_hs) begin
            r_x    <= '0;
            r_y    <= r_y + 8'd1;
            r_pack <= '0;
        end else if (w_pix_ok) begin
            r_x    <= r_x + 8'd1;
            r_pack <= {lcd_color, r_pack[7:2]};
        end
    end

    // sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
            r_line_err <= 1'b0;
        end else begin
            if (w_push && !w_wr)                           r_overflow <= 1'b1;
            if ((w_hs && r_x != LINE_PIX) || w_pix_bad)    r_line_err <= 1'b1;
        end
    end

    // FIFO storage; no reset needed since outputs are gated by empty
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= {w_back, w_lin, lcd_color, r_pack[7:2]};
    end

    // FIFO pointers with a wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
        end
    end

    // frame completion pulse when the final byte of the frame is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_frame_done <= 1'b0;
        else      r_frame_done <= w_last;
    end

`ifdef DMG_LCD_CAPTURE_DOUBLE_BUFFER_EN
    // swap buffers in the same clk that frame_done rises
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_front <= 1'b0;
        else if (w_last) r_front <= ~r_front;
    end
`endif

endmodule

// File: tb/tb_dmg_lcd_capture.sv
// tb_dmg_lcd_capture: directed tests for dmg_lcd_capture (FIFO_DEPTH = 4).
module tb_dmg_lcd_capture;

`ifdef DMG_LCD_CAPTURE_DOUBLE_BUFFER_EN
    localparam logic DB = 1'b1;
`else
    localparam logic DB = 1'b0;
`endif
    // first frame after reset targets buffer 1 with double buffering
    localparam logic [13:0] B = DB ? 14'h2000 : 14'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lcd_vsync = 1'b0, lcd_hsync = 1'b0, lcd_pixel = 1'b0;
    logic [1:0]  lcd_color = 2'b00;
    logic        fb_wr_valid, fb_wr_ready = 1'b1;
    logic [13:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_front, frame_done, overflow, line_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [13:0] wa[$];
    logic [7:0]  wd[$];
    int          fd_cnt, fd_at;

    dmg_lcd_capture #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .lcd_vsync(lcd_vsync), .lcd_hsync(lcd_hsync),
        .lcd_pixel(lcd_pixel), .lcd_color(lcd_color),
        .fb_wr_valid(fb_wr_valid), .fb_wr_ready(fb_wr_ready),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_front(fb_front),
        .frame_done(frame_done), .overflow(overflow), .line_err(line_err)
    );

    always #5 clk = ~clk;

    // capture accepted writes and frame_done pulses mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            wa.delete(); wd.delete();
            fd_cnt = 0; fd_at = -1;
        end else begin
            if (fb_wr_valid && fb_wr_ready) begin
                wa.push_back(fb_addr);
                wd.push_back(fb_data);
            end
            if (frame_done) begin
                fd_cnt++;
                fd_at = wa.size();
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        lcd_vsync = 0; lcd_hsync = 0; lcd_pixel = 0; fb_wr_ready = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic vs;
        lcd_vsync = 1'b1; tick(); lcd_vsync = 1'b0;
    endtask

    task automatic hs;
        lcd_hsync = 1'b1; tick(); lcd_hsync = 1'b0;
    endtask

    task automatic pix(input logic [1:0] c);
        lcd_pixel = 1'b1; lcd_color = c; tick(); lcd_pixel = 1'b0;
    endtask

    task automatic line(input int n, input logic [1:0] c);
        for (int i = 0; i < n; i++) pix(c);
        hs();
    endtask

    task automatic drain;
        int n = 0;
        while (fb_wr_valid && n < 200) begin tick(); n++; end
        check("drain", {31'd0, fb_wr_valid}, 32'd0);
        tick(); tick();
    endtask

    initial begin
        // reset values while held in reset
        lcd_pixel = 1'b1; lcd_color = 2'b11;
        tick(); tick();
        check("rst_valid", {31'd0, fb_wr_valid}, 0);
        check("rst_addr",  {18'd0, fb_addr}, 0);
        check("rst_data",  {24'd0, fb_data}, 0);
        check("rst_front", {31'd0, fb_front}, 0);
        check("rst_fdone", {31'd0, frame_done}, 0);
        check("rst_ovf",   {31'd0, overflow}, 0);
        check("rst_lerr",  {31'd0, line_err}, 0);
        lcd_pixel = 1'b0;
        do_reset();

        // pixels before the first vsync are ignored
        for (int i = 0; i < 8; i++) pix(2'b11);
        tick();
        check("idle_nowr", wa.size(), 0);

        // one full line of shade 1
        vs();
        line(160, 2'b01);
        drain();
        check("l0_cnt",  wa.size(), 40);
        check("l0_d0",   {24'd0, wd[0]},  32'h55);
        check("l0_d39",  {24'd0, wd[39]}, 32'h55);
        check("l0_a0",   {18'd0, wa[0]},  {18'd0, B});
        check("l0_a39",  {18'd0, wa[39]}, {18'd0, B | 14'd39});
        check("l0_lerr", {31'd0, line_err}, 0);

        // colors 0,1,2,3 on line 5
        do_reset();
        vs();
        for (int i = 0; i < 5; i++) hs();
        pix(0); pix(1); pix(2); pix(3);
        drain();
        check("l5_cnt",  wa.size(), 1);
        check("l5_data", {24'd0, wd[0]}, 32'hE4);
        check("l5_addr", {18'd0, wa[0]}, {18'd0, B | 14'd200});
        check("l5_lerr", {31'd0, line_err}, 1);

        // short line of 150 pixels, then a group on the next line
        do_reset();
        vs();
        line(150, 2'b10);
        pix(3); pix(3); pix(3); pix(3);
        drain();
        check("sl_cnt",  wa.size(), 38);
        check("sl_d36",  {24'd0, wd[36]}, 32'hAA);
        check("sl_a36",  {18'd0, wa[36]}, {18'd0, B | 14'd36});
        check("sl_a37",  {18'd0, wa[37]}, {18'd0, B | 14'd40});
        check("sl_d37",  {24'd0, wd[37]}, 32'hFF);
        check("sl_lerr", {31'd0, line_err}, 1);

        // long line: 161st pixel is dropped and flagged
        do_reset();
        vs();
        for (int i = 0; i < 161; i++) pix(2'b01);
        drain();
        check("ll_cnt",  wa.size(), 40);
        check("ll_lerr", {31'd0, line_err}, 1);

        // overflow: 6 bytes into a stalled depth-4 FIFO
        do_reset();
        fb_wr_ready = 1'b0;
        vs();
        for (int i = 0; i < 24; i++) pix(2'(((i >> 2) + 1) & 3));
        tick(); tick();
        check("ov_flag",  {31'd0, overflow}, 1);
        check("ov_valid", {31'd0, fb_wr_valid}, 1);
        check("ov_hold_a", {18'd0, fb_addr}, {18'd0, B});
        check("ov_hold_d", {24'd0, fb_data}, 32'h55);
        check("ov_nowr",  wa.size(), 0);
        fb_wr_ready = 1'b1;
        drain();
        check("ov_cnt", wa.size(), 4);
        check("ov_d0",  {24'd0, wd[0]}, 32'h55);
        check("ov_d1",  {24'd0, wd[1]}, 32'hAA);
        check("ov_d2",  {24'd0, wd[2]}, 32'hFF);
        check("ov_d3",  {24'd0, wd[3]}, 32'h00);
        check("ov_a3",  {18'd0, wa[3]}, {18'd0, B | 14'd3});
        check("ov_lerr", {31'd0, line_err}, 0);

        // push and pop together on a full FIFO: no overflow
        do_reset();
        fb_wr_ready = 1'b0;
        vs();
        for (int i = 0; i < 19; i++) pix(2'(((i >> 2) + 1) & 3));
        check("sp_full", {31'd0, overflow}, 0);
        fb_wr_ready = 1'b1;
        pix(2'b01);
        drain();
        check("sp_ovf", {31'd0, overflow}, 0);
        check("sp_cnt", wa.size(), 5);
        check("sp_d4",  {24'd0, wd[4]}, 32'h55);
        check("sp_a4",  {18'd0, wa[4]}, {18'd0, B | 14'd4});

        // full 144-line frame
        do_reset();
        vs();
        for (int l = 0; l < 144; l++) line(160, 2'b01);
        drain();
        check("fr_cnt",   wa.size(), 5760);
        check("fr_last",  {18'd0, wa[5759]}, {18'd0, B | 14'd5759});
        check("fr_fdcnt", fd_cnt, 1);
        check("fr_fdat",  fd_at, 5760);
        check("fr_front", {31'd0, fb_front}, {31'd0, DB});
        check("fr_ovf",   {31'd0, overflow}, 0);
        check("fr_lerr",  {31'd0, line_err}, 0);
        // DONE ignores pixels and hsync
        line(8, 2'b11);
        drain();
        check("done_ign",  wa.size(), 5760);
        check("done_lerr", {31'd0, line_err}, 0);

        // abort at line 70, then reset during a stalled write
        do_reset();
        vs();
        for (int l = 0; l < 70; l++) line(160, 2'b01);
        vs();
        fb_wr_ready = 1'b0;
        pix(1); pix(1); pix(1); pix(1);
        tick();
        check("ab_valid", {31'd0, fb_wr_valid}, 1);
        check("ab_addr",  {18'd0, fb_addr}, {18'd0, B});
        check("ab_fd",    fd_cnt, 0);
        rst = 1'b0;
        #1;
        check("ar_valid", {31'd0, fb_wr_valid}, 0);
        check("ar_addr",  {18'd0, fb_addr}, 0);
        check("ar_data",  {24'd0, fb_data}, 0);
        check("ar_front", {31'd0, fb_front}, 0);
        check("ar_fdone", {31'd0, frame_done}, 0);
        check("ar_ovf",   {31'd0, overflow}, 0);
        check("ar_lerr",  {31'd0, line_err}, 0);
        tick();
        rst = 1'b1;
        fb_wr_ready = 1'b1;
        tick(); tick();
        check("ar_empty", {31'd0, fb_wr_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
